// File: rtl/tgate_pkg.sv
// Shared types and helpers for transmission-gate switch blocks.
// Holds the mux FSM state encoding and the select-to-one-hot decoder.
package tgate_pkg;

    typedef logic [1:0] tgate_state_t;

    localparam tgate_state_t StOpen  = 2'd0;
    localparam tgate_state_t StBreak = 2'd1;
    localparam tgate_state_t StOn    = 2'd2;

    // Widest gate vector the decoder supports; callers slice what they need.
    localparam int unsigned MaxCh = 32;

    function automatic logic [MaxCh-1:0] onehot(input logic [31:0] sel);
        onehot = '0;
        if (sel < MaxCh) begin
            onehot[sel[4:0]] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/tgate_cell.sv
// One WIDTH-bit transmission gate: complementary nmos/pmos switch pair per bit.
// No logic on the data path; the output is shared with other cells on the same bus.
module tgate_cell #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output wire  [WIDTH-1:0] out
);

    wire en_n;
    assign en_n = ~en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nmos u_n (out[i], in[i], en);
        pmos u_p (out[i], in[i], en_n);
    end

endmodule

// File: rtl/tgate_mux_bbm.sv
// N-channel break-before-make transmission-gate mux: registered one-hot gate enables,
// dead-time sequenced channel changes. Optional out pulldowns via TGATE_MUX_PULLDOWN_EN.
module tgate_mux_bbm
    import tgate_pkg::*;
#(
    parameter  int unsigned N_CH     = 4,
    parameter  int unsigned WIDTH    = 1,
    parameter  int unsigned DEAD_CYC = 2,
    localparam int unsigned SEL_W    = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sel_valid,
    input  logic [SEL_W-1:0]      sel,
    output logic                  sel_ready,
    input  logic [N_CH*WIDTH-1:0] in,
    output wire  [WIDTH-1:0]      out,
    output logic [SEL_W-1:0]      active_ch,
    output logic                  connected,
    output logic                  sel_err
);

    localparam int unsigned CntW = $clog2(DEAD_CYC + 1);
    localparam logic [CntW-1:0] DeadInit = CntW'(DEAD_CYC - 1);

    tgate_state_t     state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0] act_q, act_d;
    logic [N_CH-1:0]  gate_en_q, gate_en_d;
    logic             conn_q, conn_d;
    logic             err_q, err_d;

    logic             accept;
    logic             sel_oob;
    logic [MaxCh-1:0] oh_full;
    logic [N_CH-1:0]  oh_act;

    assign sel_ready = !rst && enable && (state_q != StBreak);
    assign accept    = sel_valid && sel_ready;
    assign sel_oob   = (32'(sel) >= N_CH);

    // Gates only ever follow the registered channel, never sel directly.
    assign oh_full = onehot(32'(act_q));
    assign oh_act  = oh_full[N_CH-1:0];

    if (N_CH < MaxCh) begin : g_unused
        logic unused_oh;
        assign unused_oh = ^oh_full[MaxCh-1:N_CH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        gate_en_d = gate_en_q;
        conn_d    = conn_q;
        err_d     = 1'b0;
        if (!enable) begin
            state_d   = StOpen;
            gate_en_d = '0;
            conn_d    = 1'b0;
        end else begin
            case (state_q)
                StOpen: begin
                    gate_en_d = '0;
                    conn_d    = 1'b0;
                    if (accept) begin
                        if (sel_oob) begin
                            err_d = 1'b1;
                        end else begin
                            act_d   = sel;
                            cnt_d   = DeadInit;
                            state_d = StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (cnt_q == '0) begin
                        gate_en_d = oh_act;
                        conn_d    = 1'b1;
                        state_d   = StOn;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
                StOn: begin
                    if (accept) begin
                        if (sel_oob) begin
                            err_d     = 1'b1;
                            gate_en_d = '0;
                            conn_d    = 1'b0;
                            state_d   = StOpen;
                        end else if (sel != act_q) begin
                            gate_en_d = '0;
                            conn_d    = 1'b0;
                            act_d     = sel;
                            cnt_d     = DeadInit;
                            state_d   = StBreak;
                        end
                    end
                end
                default: begin
                    gate_en_d = '0;
                    conn_d    = 1'b0;
                    state_d   = StOpen;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StOpen;
            cnt_q     <= '0;
            act_q     <= '0;
            gate_en_q <= '0;
            conn_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            gate_en_q <= gate_en_d;
            conn_q    <= conn_d;
            err_q     <= err_d;
        end
    end

    assign active_ch = act_q;
    assign connected = conn_q;
    assign sel_err   = err_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        tgate_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .in  (in[k*WIDTH +: WIDTH]),
            .en  (gate_en_q[k]),
            .out (out)
        );
    end

`ifdef TGATE_MUX_PULLDOWN_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_pd
        pulldown u_pd (out[i]);
    end
`endif

endmodule

// File: tb/tb_tgate_mux_bbm.sv
// Bench for tgate_mux_bbm: table-driven vectors through a scoreboard queue on a 4-channel
// instance, plus hand sequences for async reset and out-of-range select on a 3-channel one.
module tb_tgate_mux_bbm;
    import tgate_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4-channel instance, channel 2 carries 1
    logic       en_a, v_a, rdy_a, conn_a, err_a;
    logic [1:0] sel_a, act_a;
    logic [3:0] in_a;
    wire  [0:0] out_a;

    // 3-channel instance, channel 0 carries 1
    logic       en_b, v_b, rdy_b, conn_b, err_b;
    logic [1:0] sel_b, act_b;
    logic [2:0] in_b;
    wire  [0:0] out_b;

    tgate_mux_bbm #(.N_CH(4), .WIDTH(1), .DEAD_CYC(2)) dut_a (
        .clk (clk), .rst (rst), .enable (en_a), .sel_valid (v_a), .sel (sel_a),
        .sel_ready (rdy_a), .in (in_a), .out (out_a), .active_ch (act_a),
        .connected (conn_a), .sel_err (err_a)
    );

    tgate_mux_bbm #(.N_CH(3), .WIDTH(1), .DEAD_CYC(2)) dut_b (
        .clk (clk), .rst (rst), .enable (en_b), .sel_valid (v_b), .sel (sel_b),
        .sel_ready (rdy_b), .in (in_b), .out (out_b), .active_ch (act_b),
        .connected (conn_b), .sel_err (err_b)
    );

    typedef struct packed {
        logic       en;
        logic       v;
        logic [1:0] sel;
        logic       conn;
        logic [1:0] act;
        logic [3:0] gate;
        logic       err;
        logic       rdy;
    } vec_t;

    localparam int NumVec = 21;
    vec_t vecs [NumVec];
    vec_t sb_q [$];

    int checks   = 0;
    int failures = 0;
    int inv_err  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // No two gates at once, and no gate while the dead time runs.
    always @(negedge clk) begin
        if (!rst) begin
            if (!$onehot0(dut_a.gate_en_q) || !$onehot0(dut_b.gate_en_q)) inv_err++;
            if (dut_a.state_q == StBreak && dut_a.gate_en_q != '0) inv_err++;
            if (dut_b.state_q == StBreak && dut_b.gate_en_q != '0) inv_err++;
        end
    end

    task automatic run_vec(input vec_t v);
        vec_t e;
        en_a  = v.en;
        v_a   = v.v;
        sel_a = v.sel;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("connected", 32'(conn_a), 32'(e.conn));
        chk("active_ch", 32'(act_a), 32'(e.act));
        chk("gate_en", 32'(dut_a.gate_en_q), 32'(e.gate));
        chk("sel_err", 32'(err_a), 32'(e.err));
        chk("sel_ready", 32'(rdy_a), 32'(e.rdy));
        if (e.conn) chk("out_on", 32'(out_a), 32'(in_a[e.act]));
`ifdef TGATE_MUX_PULLDOWN_EN
        else chk("out_pulled", 32'(out_a), 32'd0);
`endif
    endtask

    initial begin
        //            en    v     sel    conn  act    gate     err   rdy
        vecs[0]  = {1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b1}; // idle OPEN
        vecs[1]  = {1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0}; // accept ch2
        vecs[2]  = {1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[3]  = {1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1}; // ch2 on at t+2
        vecs[4]  = {1'b1, 1'b1, 2'd2, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1}; // same ch: no-op
        vecs[5]  = {1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}; // switch to ch1
        vecs[6]  = {1'b1, 1'b1, 2'd3, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}; // held off in BREAK
        vecs[7]  = {1'b1, 1'b1, 2'd3, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b1}; // ch1 on
        vecs[8]  = {1'b1, 1'b1, 2'd3, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0}; // held req accepted
        vecs[9]  = {1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 4'b0000, 1'b0, 1'b0};
        vecs[10] = {1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b1};
        vecs[11] = {1'b1, 1'b1, 2'd2, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[12] = {1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0};
        vecs[13] = {1'b1, 1'b0, 2'd0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b1};
        vecs[14] = {1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b0}; // enable drop in ON
        vecs[15] = {1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b1}; // no reconnect
        vecs[16] = {1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 4'b0000, 1'b0, 1'b1};
        vecs[17] = {1'b1, 1'b1, 2'd1, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}; // accept ch1
        vecs[18] = {1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b0}; // abandon BREAK
        vecs[19] = {1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1};
        vecs[20] = {1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 4'b0000, 1'b0, 1'b1};

        rst   = 1'b1;
        en_a  = 1'b1;
        v_a   = 1'b0;
        sel_a = 2'd0;
        in_a  = 4'b0100;
        en_b  = 1'b1;
        v_b   = 1'b0;
        sel_b = 2'd0;
        in_b  = 3'b001;

        #12;
        chk("rst_connected", 32'(conn_a), 32'd0);
        chk("rst_active_ch", 32'(act_a), 32'd0);
        chk("rst_gate_en", 32'(dut_a.gate_en_q), 32'd0);
        chk("rst_sel_err", 32'(err_a), 32'd0);
        chk("rst_sel_ready", 32'(rdy_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NumVec; i++) begin
            run_vec(vecs[i]);
        end

        // Async reset while ON: gates open before the next clock edge.
        sel_a = 2'd2;
        v_a   = 1'b1;
        @(posedge clk);
        #1;
        v_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_gate_en", 32'(dut_a.gate_en_q), 32'h4);
        chk("pre_rst_connected", 32'(conn_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_gate_en", 32'(dut_a.gate_en_q), 32'd0);
        chk("async_rst_connected", 32'(conn_a), 32'd0);
        chk("async_rst_active_ch", 32'(act_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_gate_en", 32'(dut_a.gate_en_q), 32'd0);
        chk("post_rst_connected", 32'(conn_a), 32'd0);

        // 3-channel instance: connect ch0, then an out-of-range select.
        sel_b = 2'd0;
        v_b   = 1'b1;
        @(posedge clk);
        #1;
        v_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("b_connected", 32'(conn_b), 32'd1);
        chk("b_out_on", 32'(out_b), 32'd1);
        chk("b_gate_en", 32'(dut_b.gate_en_q), 32'h1);
        sel_b = 2'd3;
        v_b   = 1'b1;
        @(posedge clk);
        #1;
        v_b = 1'b0;
        chk("b_oob_sel_err", 32'(err_b), 32'd1);
        chk("b_oob_gate_en", 32'(dut_b.gate_en_q), 32'd0);
        chk("b_oob_connected", 32'(conn_b), 32'd0);
        chk("b_oob_active_ch", 32'(act_b), 32'd0);
`ifdef TGATE_MUX_PULLDOWN_EN
        chk("b_oob_out_pulled", 32'(out_b), 32'd0);
`endif
        @(posedge clk);
        #1;
        chk("b_err_pulse_end", 32'(err_b), 32'd0);
        chk("b_open_ready", 32'(rdy_b), 32'd1);
        chk("b_open_connected", 32'(conn_b), 32'd0);
        // Out-of-range straight from OPEN.
        sel_b = 2'd3;
        v_b   = 1'b1;
        @(posedge clk);
        #1;
        v_b = 1'b0;
        chk("b_open_oob_err", 32'(err_b), 32'd1);
        chk("b_open_oob_active", 32'(act_b), 32'd0);
        chk("b_open_oob_state", 32'(dut_b.state_q), 32'(StOpen));

        chk("gate_invariant", 32'(inv_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
